// File: rtl/cft_cpu_core_if.sv
// CFT card-edge bus (ec_*) between the CPU core and memory/ROM.
// Tri-state resolution of ec_ab/ec_db lives here so each side only drives data + enable.
interface cft_cpu_core_if;
  logic [15:0] ab_out;
  logic        ab_oe;
  logic [15:0] db_out;
  logic        db_oe;
  logic [15:0] ext_db;
  logic        ext_oe;
  logic        ec_nmem;
  logic        ec_nio;
  logic        ec_nr;
  logic        ec_nw;
  logic        ec_clk1;
  logic        ec_clk2;
  logic        ec_clk3;
  logic        ec_clk4;
  logic        ec_nt34;
  wire  [15:0] ec_ab;
  wire  [15:0] ec_db;

  assign ec_ab = ab_oe ? ab_out : 16'hzzzz;
  assign ec_db = db_oe ? db_out : (ext_oe ? ext_db : 16'hzzzz);

  modport master (
    output ab_out, ab_oe, db_out, db_oe,
    output ec_nmem, ec_nio, ec_nr, ec_nw,
    output ec_clk1, ec_clk2, ec_clk3, ec_clk4, ec_nt34,
    input  ec_db
  );

  modport slave (
    input  ec_ab, ec_db, ec_nmem, ec_nr, ec_nw,
    output ext_db, ext_oe
  );
endinterface

// File: rtl/cft_cpu_core.sv
// 16-bit accumulator CPU for the CFT bus: fetch/decode/indirect/execute, one bus step
// per four master clocks, plus generation of the four-phase bus clocks.
module cft_cpu_core #(
  parameter logic [15:0] RESET_VECTOR = 16'hFFF0
) (
  input  logic           ec_clk,
  input  logic           ec_reset,
  cft_cpu_core_if.master bus
);
  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_INDIRECT, S_EXEC} state_t;

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_OPR   = 4'hD;

  state_t      state_reg, state_next;
  logic [1:0]  phase_reg;
  logic        idle_reg;
  logic [15:0] pc_reg, pc_next;
  logic [15:0] ac_reg, ac_next;
  logic [15:0] ir_reg, ir_next;
  logic [15:0] ea_reg, ea_next;
  logic [3:0]  op;
  logic [15:0] ea_form;
  logic [15:0] opr_ac;
  logic        mem_ref;
  logic        step_end;
  logic        bus_rd;
  logic        bus_wr;
  logic        bus_act;

  assign op       = ir_reg[15:12];
  assign mem_ref  = (op == OP_LOAD) || (op == OP_STORE) || (op == OP_ADD) || (op == OP_AND);
  // idle_reg covers the cycle right after reset, so the first step starts cleanly at p0
  assign step_end = !idle_reg && (phase_reg == 2'd3);
  // pc_reg already points past the instruction while in DECODE
  assign ea_form  = {(ir_reg[10] ? 6'd0 : pc_reg[15:10]), ir_reg[9:0]};

  always_comb begin
    opr_ac = ac_reg;
    if (ir_reg[0]) opr_ac = 16'h0000;
    if (ir_reg[1]) opr_ac = ~opr_ac;
    if (ir_reg[2]) opr_ac = opr_ac + 16'd1;
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ac_next    = ac_reg;
    ir_next    = ir_reg;
    ea_next    = ea_reg;
    if (step_end) begin
      case (state_reg)
        S_FETCH: begin
          ir_next    = bus.ec_db;
          pc_next    = pc_reg + 16'd1;
          state_next = S_DECODE;
        end
        S_DECODE: begin
          ea_next    = ea_form;
          state_next = S_FETCH;
          if (ir_reg[11] && (mem_ref || (op == OP_JMP))) state_next = S_INDIRECT;
          else if (op == OP_JMP)                         pc_next    = ea_form;
          else if (op == OP_OPR)                         ac_next    = opr_ac;
          else if (mem_ref)                              state_next = S_EXEC;
        end
        S_INDIRECT: begin
          ea_next = bus.ec_db;
          if (op == OP_JMP) begin
            pc_next    = bus.ec_db;
            state_next = S_FETCH;
          end else begin
            state_next = S_EXEC;
          end
        end
        default: begin
          state_next = S_FETCH;
          case (op)
            OP_LOAD: ac_next = bus.ec_db;
            OP_ADD:  ac_next = ac_reg + bus.ec_db;
            OP_AND:  ac_next = ac_reg & bus.ec_db;
            default: ac_next = ac_reg;
          endcase
        end
      endcase
    end
  end

  always_comb begin
    bus_rd = 1'b0;
    bus_wr = 1'b0;
    if (!idle_reg) begin
      case (state_reg)
        S_FETCH, S_INDIRECT: bus_rd = 1'b1;
        S_EXEC: begin
          if (op == OP_STORE) bus_wr = 1'b1;
          else                bus_rd = 1'b1;
        end
        default: begin
          bus_rd = 1'b0;
          bus_wr = 1'b0;
        end
      endcase
    end
  end

  assign bus_act     = bus_rd || bus_wr;
  assign bus.ab_oe   = bus_act;
  assign bus.ab_out  = (state_reg == S_FETCH) ? pc_reg : ea_reg;
  assign bus.db_oe   = bus_wr;
  assign bus.db_out  = ac_reg;
  assign bus.ec_nmem = !(bus_act && (phase_reg != 2'd0));
  assign bus.ec_nr   = !(bus_rd && (phase_reg != 2'd0));
  assign bus.ec_nw   = !(bus_wr && ((phase_reg == 2'd1) || (phase_reg == 2'd2)));
  assign bus.ec_nio  = 1'b1;
  assign bus.ec_clk1 = (phase_reg != 2'd1);
  assign bus.ec_clk2 = (phase_reg != 2'd2);
  assign bus.ec_clk3 = (phase_reg != 2'd3);
  assign bus.ec_clk4 = (phase_reg != 2'd0);
  assign bus.ec_nt34 = !phase_reg[1];

  always_ff @(posedge ec_clk) begin
    if (ec_reset) begin
      state_reg <= S_FETCH;
      phase_reg <= 2'd0;
      idle_reg  <= 1'b1;
      pc_reg    <= RESET_VECTOR;
      ac_reg    <= 16'h0000;
      ir_reg    <= 16'h0000;
      ea_reg    <= 16'h0000;
    end else begin
      idle_reg  <= 1'b0;
      if (!idle_reg) phase_reg <= phase_reg + 2'd1;
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ac_reg    <= ac_next;
      ir_reg    <= ir_next;
      ea_reg    <= ea_next;
    end
  end
endmodule

// File: tb/tb_cft_cpu_core.sv
// Bench for cft_cpu_core: instruction-level model producing expected bus steps,
// compared cycle by cycle, plus literal expectations on logged bus traffic.
module tb_cft_cpu_core;
  logic ec_clk;
  logic ec_reset;

  cft_cpu_core_if bus ();

  cft_cpu_core #(.RESET_VECTOR(16'hFFF0)) dut (
    .ec_clk   (ec_clk),
    .ec_reset (ec_reset),
    .bus      (bus)
  );

  initial ec_clk = 1'b0;
  always #5 ec_clk = ~ec_clk;

  // Memory seen by the DUT (read-only environment)
  logic [15:0] mem [0:65535];
  assign bus.ext_oe = (bus.ec_nr == 1'b0);
  assign bus.ext_db = mem[bus.ec_ab];

  typedef struct packed {
    logic [1:0]  kind;   // 0 idle, 1 read, 2 write
    logic [15:0] addr;
    logic [15:0] data;
  } step_t;

  // Model state
  logic [15:0] mmem [0:65535];
  logic [15:0] m_pc;
  logic [15:0] m_ac;
  step_t       step_q [$];

  int          n_checks;
  int          n_errors;
  logic        checking;
  int          cyc;
  int          ph;
  step_t       cur;
  logic [15:0] ab_log [$];
  int          cyc_log [$];
  logic [31:0] wr_log [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input logic [15:0] a, input logic [15:0] d);
    step_t s;
    s.kind = k[1:0];
    s.addr = a;
    s.data = d;
    step_q.push_back(s);
  endtask

  // Executes one whole instruction and queues the bus steps it must produce
  task automatic model_instr();
    logic [15:0] ins;
    logic [15:0] ea;
    logic [3:0]  op;
    logic        is_mem;
    ins = mmem[m_pc];
    push(1, m_pc, 16'h0);
    m_pc = m_pc + 16'd1;
    push(0, 16'h0, 16'h0);
    op = ins[15:12];
    ea = ins[10] ? {6'd0, ins[9:0]} : {m_pc[15:10], ins[9:0]};
    is_mem = (op == 4'h1) || (op == 4'h2) || (op == 4'h3) || (op == 4'h4);
    if (ins[11] && (is_mem || op == 4'h6)) begin
      push(1, ea, 16'h0);
      ea = mmem[ea];
    end
    case (op)
      4'h1: begin push(1, ea, 16'h0); m_ac = mmem[ea]; end
      4'h2: begin push(2, ea, m_ac); mmem[ea] = m_ac; end
      4'h3: begin push(1, ea, 16'h0); m_ac = m_ac + mmem[ea]; end
      4'h4: begin push(1, ea, 16'h0); m_ac = m_ac & mmem[ea]; end
      4'h6: m_pc = ea;
      4'hD: begin
        if (ins[0]) m_ac = 16'h0;
        if (ins[1]) m_ac = ~m_ac;
        if (ins[2]) m_ac = m_ac + 16'd1;
      end
      default: ;
    endcase
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    mem[a]  = d;
    mmem[a] = d;
  endtask

  task automatic load_prog(input int which);
    for (int i = 0; i < 65536; i++) begin
      mem[i]  = 16'h0;
      mmem[i] = 16'h0;
    end
    if (which == 0) begin
      poke(16'hFFF0, 16'hD000);
      poke(16'hFFF1, 16'hD000);
      poke(16'hFFF2, 16'hD000);
      poke(16'hFFF3, 16'h63F0);
    end else begin
      poke(16'hFFF0, 16'h6500);  // JMP page0 0x100
      poke(16'h0100, 16'h1120);  // LOAD 0120
      poke(16'h0101, 16'h3121);  // ADD 0121
      poke(16'h0102, 16'h2122);  // STORE 0122
      poke(16'h0103, 16'h1124);  // LOAD 0124
      poke(16'h0104, 16'hD007);  // CLA CMA INC
      poke(16'h0105, 16'h2123);  // STORE 0123
      poke(16'h0106, 16'h1124);  // LOAD 0124
      poke(16'h0107, 16'h4125);  // AND 0125
      poke(16'h0108, 16'hD006);  // CMA INC
      poke(16'h0109, 16'h2126);  // STORE 0126
      poke(16'h010A, 16'h1C11);  // LOAD indirect via 0011
      poke(16'h010B, 16'h2127);  // STORE 0127
      poke(16'h010C, 16'h7000);  // undefined
      poke(16'h010D, 16'h6C10);  // JMP indirect via 0010
      poke(16'h0010, 16'hFFF0);
      poke(16'h0011, 16'h0125);
      poke(16'h0120, 16'hFFFF);
      poke(16'h0121, 16'h0002);
      poke(16'h0124, 16'h1234);
      poke(16'h0125, 16'h0FF0);
    end
  endtask

  task automatic start_run();
    checking = 1'b0;
    ec_reset = 1'b1;
    repeat (4) @(posedge ec_clk);
    #1;
    ec_reset = 1'b0;
    m_pc = 16'hFFF0;
    m_ac = 16'h0000;
    step_q.delete();
    ab_log.delete();
    cyc_log.delete();
    wr_log.delete();
    cyc = 0;
    checking = 1'b1;
  endtask

  function automatic logic [15:0] ab_at(input int i);
    return (i < ab_log.size()) ? ab_log[i] : 16'hDEAD;
  endfunction

  function automatic logic [31:0] wr_at(input int i);
    return (i < wr_log.size()) ? wr_log[i] : 32'hDEADDEAD;
  endfunction

  always @(negedge ec_clk) begin
    if (checking) begin
      if (cyc == 0) begin
        ph  = 0;
        cur = '0;
      end else begin
        ph = (cyc - 1) % 4;
        if (ph == 0) begin
          if (step_q.size() == 0) model_instr();
          cur = step_q.pop_front();
        end
      end
      check("phase_clks",
            {27'd0, bus.ec_clk1, bus.ec_clk2, bus.ec_clk3, bus.ec_clk4, bus.ec_nt34},
            {27'd0, ph != 1, ph != 2, ph != 3, ph != 0, ph < 2});
      check("strobes",
            {28'd0, bus.ec_nmem, bus.ec_nio, bus.ec_nr, bus.ec_nw},
            {28'd0, !(cur.kind != 2'd0 && ph != 0), 1'b1,
             !(cur.kind == 2'd1 && ph != 0), !(cur.kind == 2'd2 && (ph == 1 || ph == 2))});
      check("ab_oe", {31'd0, bus.ab_oe}, {31'd0, cur.kind != 2'd0});
      if (cur.kind != 2'd0) check("ab", {16'd0, bus.ec_ab}, {16'd0, cur.addr});
      check("db_oe", {31'd0, bus.db_oe}, {31'd0, cur.kind == 2'd2});
      if (cur.kind == 2'd2) check("db", {16'd0, bus.ec_db}, {16'd0, cur.data});
      if (ph == 1 && cyc > 0) begin
        if (bus.ab_oe) begin
          ab_log.push_back(bus.ec_ab);
          cyc_log.push_back(cyc);
        end
        if (!bus.ec_nw) wr_log.push_back({bus.ec_ab, bus.ec_db});
      end
      cyc++;
    end
  end

  initial begin
    int  found;
    logic [15:0] after_ind;
    n_checks = 0;
    n_errors = 0;
    checking = 1'b0;
    ec_reset = 1'b1;
    cyc      = 0;

    // NOP loop in ROM
    load_prog(0);
    start_run();
    @(negedge ec_clk);
    check("rst_clks", {27'd0, bus.ec_clk1, bus.ec_clk2, bus.ec_clk3, bus.ec_clk4, bus.ec_nt34},
          32'h0000001D);
    check("rst_strobes", {28'd0, bus.ec_nmem, bus.ec_nio, bus.ec_nr, bus.ec_nw}, 32'h0000000F);
    check("rst_oe", {30'd0, bus.ab_oe, bus.db_oe}, 32'h0);
    repeat (70) @(negedge ec_clk);
    checking = 1'b0;
    check("loop_first_fetch", {16'd0, ab_at(0)}, 32'h0000FFF0);
    check("loop_jmp_fetch", {16'd0, ab_at(3)}, 32'h0000FFF3);
    check("loop_wrap_fetch", {16'd0, ab_at(4)}, 32'h0000FFF0);
    check("loop_period", (cyc_log.size() > 4) ? cyc_log[4] - cyc_log[0] : -1, 32);

    // Arithmetic, micro-ops, indirect addressing
    load_prog(1);
    start_run();
    repeat (360) @(negedge ec_clk);
    checking = 1'b0;
    check("store_ab_db", wr_at(0), 32'h01220001);
    check("d007_result", wr_at(1), 32'h01230000);
    check("and_negate", wr_at(2), 32'h0126FDD0);
    check("indirect_load", wr_at(3), 32'h01270FF0);
    after_ind = 16'hDEAD;
    for (int i = 0; i + 1 < ab_log.size(); i++) begin
      if (ab_log[i] == 16'h0010 && after_ind == 16'hDEAD) after_ind = ab_log[i + 1];
    end
    check("ind_jmp_target", {16'd0, after_ind}, 32'h0000FFF0);

    // Reset in p2 of a write step
    start_run();
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      @(negedge ec_clk);
      if (bus.ec_nw == 1'b0) found = 1;
    end
    check("write_step_seen", found, 1);
    @(posedge ec_clk);
    #1;
    checking = 1'b0;
    ec_reset = 1'b1;
    @(posedge ec_clk);
    @(negedge ec_clk);
    check("abort_strobes", {29'd0, bus.ec_nw, bus.ec_nmem, bus.ec_nr}, 32'h7);
    check("abort_oe", {30'd0, bus.ab_oe, bus.db_oe}, 32'h0);
    check("abort_clk4", {31'd0, bus.ec_clk4}, 32'h0);
    start_run();
    repeat (40) @(negedge ec_clk);
    checking = 1'b0;
    check("restart_fetch", {16'd0, ab_at(0)}, 32'h0000FFF0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
